// File: rtl/uart_rx_frame_parser_if.sv
// rtl/uart_rx_frame_parser_if.sv - byte stream in, held-frame readout and status out
interface uart_rx_frame_parser_if #(
  parameter int ADDR_W = 4
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic [7:0]        frame_len;
  logic              frame_valid;
  logic              frame_ack;
  logic              frame_error;
  logic [1:0]        err_code;
  logic              overrun;

  modport slave (
    input  rx_data, rx_valid, rd_addr, frame_ack,
    output rd_data, frame_len, frame_valid, frame_error, err_code, overrun
  );

  modport master (
    output rx_data, rx_valid, rd_addr, frame_ack,
    input  rd_data, frame_len, frame_valid, frame_error, err_code, overrun
  );
endinterface

// File: rtl/uart_rx_frame_parser.sv
// rtl/uart_rx_frame_parser.sv - delineates HEADER/LEN/payload/CHK frames from a UART byte stream
// and holds a validated payload until the consumer acknowledges it.
module uart_rx_frame_parser #(
  parameter logic [7:0] HEADER  = 8'hAA,
  parameter int         MAX_LEN = 16,
  parameter int         ADDR_W  = 4,
  parameter int         TIMEOUT = 50000
) (
  input logic                  clk,
  input logic                  reset,
  uart_rx_frame_parser_if.slave bus
);

  localparam int         CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CHECK, DONE} state_t;

  state_t           state, state_next;
  logic [7:0]       mem [2**ADDR_W];
  logic [7:0]       idx;
  logic [7:0]       cksum;
  logic [7:0]       len_q;
  logic [CNT_W-1:0] cnt;
  logic             err_q, ovr_q;
  logic [1:0]       code_q;
  logic             active, tout, load_len, wr_en;
  logic             err_set, ovr_set;
  logic [1:0]       err_val;

  assign active   = (state == LEN) || (state == PAYLOAD) || (state == CHECK);
  // A timeout wins over a byte arriving in the same cycle; that byte is lost.
  assign tout     = active && (cnt == CNT_W'(TIMEOUT));
  assign load_len = (state == LEN) && bus.rx_valid && !tout;
  assign wr_en    = (state == PAYLOAD) && bus.rx_valid && !tout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    err_set    = 1'b0;
    err_val    = 2'b00;
    ovr_set    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.rx_valid && bus.rx_data == HEADER) state_next = LEN;
      end
      LEN: begin
        if (tout) begin
          state_next = IDLE; err_set = 1'b1; err_val = 2'b11;
        end else if (bus.rx_valid) begin
          if (bus.rx_data > MAX_LEN_B) begin
            state_next = IDLE; err_set = 1'b1; err_val = 2'b01;
          end else if (bus.rx_data == 8'd0) begin
            state_next = CHECK;
          end else begin
            state_next = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (tout) begin
          state_next = IDLE; err_set = 1'b1; err_val = 2'b11;
        end else if (bus.rx_valid && idx == len_q - 8'd1) begin
          state_next = CHECK;
        end
      end
      CHECK: begin
        if (tout) begin
          state_next = IDLE; err_set = 1'b1; err_val = 2'b11;
        end else if (bus.rx_valid) begin
          if (bus.rx_data == cksum) begin
            state_next = DONE;
          end else begin
            state_next = IDLE; err_set = 1'b1; err_val = 2'b10;
          end
        end
      end
      DONE: begin
        // Bytes arriving while a frame is held are dropped, even alongside the ack.
        ovr_set = bus.rx_valid;
        if (bus.frame_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      idx    <= 8'd0;
      cksum  <= 8'd0;
      len_q  <= 8'd0;
      err_q  <= 1'b0;
      ovr_q  <= 1'b0;
      code_q <= 2'b00;
    end else begin
      if (!active || tout || bus.rx_valid) cnt <= '0;
      else                                 cnt <= cnt + 1'b1;
      if (load_len) begin
        cksum <= bus.rx_data;
        len_q <= bus.rx_data;
        idx   <= 8'd0;
      end else if (wr_en) begin
        cksum <= cksum ^ bus.rx_data;
        idx   <= idx + 8'd1;
      end
      err_q <= err_set;
      ovr_q <= ovr_set;
      if (err_set) code_q <= err_val;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[idx[ADDR_W-1:0]] <= bus.rx_data;
  end

  assign bus.rd_data     = mem[bus.rd_addr];
  assign bus.frame_len   = len_q;
  assign bus.frame_valid = (state == DONE);
  assign bus.frame_error = err_q;
  assign bus.err_code    = code_q;
  assign bus.overrun     = ovr_q;

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// tb/tb_uart_rx_frame_parser.sv - randomized frames checked against a frame-level parse model
module tb_uart_rx_frame_parser;
  localparam logic [7:0] HEADER  = 8'hAA;
  localparam int         MAX_LEN = 16;
  localparam int         TIMEOUT = 50000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  uart_rx_frame_parser_if #(.ADDR_W(4)) bus ();

  uart_rx_frame_parser #(.HEADER(HEADER), .MAX_LEN(MAX_LEN), .ADDR_W(4), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int err_cnt = 0, ovr_cnt = 0, cyc = 0, err_cyc = 0;
  logic fv_prev = 1'b0;
  logic [1:0] exp_code = 2'b00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (bus.frame_error === 1'b1) begin err_cnt++; err_cyc = cyc; end
    if (bus.overrun === 1'b1) ovr_cnt++;
    check("pulse_on_rise", 32'((bus.frame_error | bus.overrun) & bus.frame_valid & ~fv_prev), 0);
    fv_prev = bus.frame_valid;
  end

  // Frame-level reading of a byte list starting from an idle parser.
  function automatic void model(input logic [7:0] q[$], output int ne, output logic [1:0] code,
                                output bit held, output int len, output logic [7:0] pl [16]);
    int i = 0;
    logic [7:0] c;
    ne = 0; code = 2'b00; held = 0; len = 0;
    for (int k = 0; k < 16; k++) pl[k] = 8'h00;
    while (i < q.size() && !held) begin
      if (q[i] != HEADER) begin i++; continue; end
      if (i + 1 >= q.size()) break;
      len = int'(q[i+1]);
      if (len > MAX_LEN) begin ne++; code = 2'b01; i += 2; continue; end
      if (i + 2 + len >= q.size()) break;
      c = q[i+1];
      for (int k = 0; k < len; k++) c ^= q[i+2+k];
      if (q[i+2+len] == c) begin
        held = 1;
        for (int k = 0; k < len; k++) pl[k] = q[i+2+k];
      end else begin
        ne++; code = 2'b10; i += len + 3;
      end
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic ack);
    bus.rx_data = b; bus.rx_valid = 1'b1; bus.frame_ack = ack;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0; bus.frame_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic run_round(input logic [7:0] q[$], input int n_ovr, input bit ack_with, input bit gaps);
    int ne, len, e0, o0;
    logic [1:0] code;
    bit held;
    logic [7:0] pl [16];
    model(q, ne, code, held, len, pl);
    e0 = err_cnt; o0 = ovr_cnt;
    foreach (q[i]) begin
      if (i == q.size() - 1) check("fv_before_chk", 32'(bus.frame_valid), 0);
      send_byte(q[i], 1'b0);
      if (gaps && i < q.size() - 1) idle($urandom_range(0, 2));
    end
    @(negedge clk);
    check("fv_after_chk", 32'(bus.frame_valid), 32'(held));
    idle(1);
    @(negedge clk);
    check("err_count", 32'(err_cnt - e0), 32'(ne));
    if (ne > 0) exp_code = code;
    check("err_code", 32'(bus.err_code), 32'(exp_code));
    if (held) begin
      check("frame_len", 32'(bus.frame_len), 32'(len));
      for (int k = 0; k < len; k++) begin
        bus.rd_addr = 4'(k); #1;
        check("rd_data", 32'(bus.rd_data), 32'(pl[k]));
      end
      idle(1);
      for (int k = 0; k < n_ovr; k++) begin
        if (k == n_ovr - 1 && ack_with) send_byte(HEADER, 1'b1);
        else send_byte(8'($urandom), 1'b0);
      end
      @(negedge clk);
      check("len_frozen", 32'(bus.frame_len), 32'(len));
      if (len > 0) begin
        bus.rd_addr = 4'd0; #1;
        check("buf_frozen", 32'(bus.rd_data), 32'(pl[0]));
      end
      idle(1);
      if (!(ack_with && n_ovr > 0)) begin
        bus.frame_ack = 1'b1; idle(1); bus.frame_ack = 1'b0;
      end
      @(negedge clk);
      check("fv_after_ack", 32'(bus.frame_valid), 0);
      check("overrun_count", 32'(ovr_cnt - o0), 32'(n_ovr));
      idle(1);
    end
  endtask

  initial begin
    logic [7:0] q[$];
    int kind, len, e0, t0;
    logic [7:0] c;
    bus.rx_data = 8'h00; bus.rx_valid = 1'b0; bus.rd_addr = '0; bus.frame_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_fv", 32'(bus.frame_valid), 0);
    check("rst_fe", 32'(bus.frame_error), 0);
    check("rst_ovr", 32'(bus.overrun), 0);
    check("rst_code", 32'(bus.err_code), 0);
    check("rst_len", 32'(bus.frame_len), 0);
    @(posedge clk); #1 reset = 1'b0;
    idle(2);

    run_round('{8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03}, 0, 0, 0);
    run_round('{8'hAA, 8'h02, 8'h10, 8'h20, 8'h31}, 0, 0, 0);
    run_round('{8'hAA, 8'h00, 8'h00}, 0, 0, 0);
    run_round('{8'hAA, 8'h11, 8'h05}, 0, 0, 0);
    run_round('{8'hAA, 8'h01, 8'h77, 8'h76}, 1, 1, 0);
    run_round('{8'h01, 8'h77, 8'h76}, 0, 0, 0);

    e0 = err_cnt;
    send_byte(8'hAA, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h10, 1'b0);
    t0 = cyc;
    for (int k = 0; k < TIMEOUT + 10; k++) begin
      @(negedge clk);
      if (err_cnt != e0) break;
    end
    #1;
    check("timeout_pulse", 32'(err_cnt - e0), 1);
    check("timeout_delay", 32'((err_cyc - t0 >= TIMEOUT) && (err_cyc - t0 <= TIMEOUT + 2)), 1);
    check("timeout_code", 32'(bus.err_code), 32'(2'b11));
    exp_code = 2'b11;
    idle(1);
    run_round('{8'hAA, 8'h02, 8'hAA, 8'h5A, 8'hF2}, 0, 0, 1);

    send_byte(8'hAA, 1'b0); send_byte(8'h03, 1'b0); send_byte(8'h11, 1'b0);
    e0 = err_cnt;
    #2 reset = 1'b1; #1;
    check("mid_rst_fv", 32'(bus.frame_valid), 0);
    check("mid_rst_code", 32'(bus.err_code), 0);
    check("mid_rst_len", 32'(bus.frame_len), 0);
    check("mid_rst_fe", 32'(bus.frame_error), 0);
    exp_code = 2'b00;
    idle(2);
    reset = 1'b0;
    idle(1);
    check("mid_rst_no_err", 32'(err_cnt - e0), 0);
    run_round('{8'hAA, 8'h01, 8'h55, 8'h54}, 0, 0, 0);

    for (int r = 0; r < 40; r++) begin
      q = {};
      repeat ($urandom_range(0, 3)) begin
        c = 8'($urandom);
        q.push_back(c == HEADER ? 8'h55 : c);
      end
      kind = $urandom_range(0, 3);
      len = (kind == 2) ? $urandom_range(MAX_LEN + 1, 255) : $urandom_range(0, MAX_LEN);
      q.push_back(HEADER);
      q.push_back(8'(len));
      if (kind != 2) begin
        c = 8'(len);
        for (int k = 0; k < len; k++) begin
          q.push_back(($urandom_range(0, 7) == 0) ? HEADER : 8'($urandom));
          c ^= q[q.size() - 1];
        end
        if (kind == 1) c ^= 8'($urandom_range(1, 255));
        q.push_back(c);
      end
      run_round(q, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
